// File: rtl/param_memory_pkg.sv
// Shared types and helpers for the parametrised register-file memory.
package param_memory_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // Low bit of slice idx in a bus packed from w-bit fields.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/mem_read_port.sv
// One registered read port with write-first bypass and a one-cycle valid flag.
module mem_read_port #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q,
  output logic              rvalid
);

  logic hit_c;

  assign hit_c = we && (waddr == raddr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q      <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) begin
        q <= hit_c ? wdata : rdata;
      end
    end
  end

endmodule

// File: rtl/param_memory.sv
// DEPTH x DATA_W storage with one write port, NRD registered read ports and a clear sweeper.
module param_memory
  import param_memory_pkg::*;
#(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned NRD    = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    WE,
  input  logic [ADDR_W-1:0]       WADDR,
  input  logic [DATA_W-1:0]       D,
  input  logic [NRD-1:0]          RE,
  input  logic [NRD*ADDR_W-1:0]   RADDR,
  output logic [NRD*DATA_W-1:0]   Q,
  output logic [NRD-1:0]          RVALID,
  input  logic                    CLR,
  output logic                    BUSY
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              idle_c;
  logic              we_c;

  assign idle_c = (state == IDLE);
  // A clear request on the same edge takes priority over the write.
  assign we_c   = WE && idle_c && !CLR;

  // Array, write port and clear sequencer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem   <= '{default: '0};
      state <= IDLE;
      ptr   <= '0;
      BUSY  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (CLR) begin
            state <= SWEEP;
            ptr   <= '0;
            BUSY  <= 1'b1;
          end else if (WE) begin
            mem[WADDR] <= D;
          end
        end
        SWEEP: begin
          mem[ptr] <= '0;
          ptr      <= ptr + ADDR_W'(1);
          if (ptr == LAST) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
    localparam int unsigned RA = slice_lo(i, ADDR_W);
    localparam int unsigned RD = slice_lo(i, DATA_W);

    logic [ADDR_W-1:0] raddr_c;
    logic [DATA_W-1:0] rword_c;

    assign raddr_c = RADDR[RA +: ADDR_W];
    assign rword_c = mem[raddr_c];

    mem_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .clk    (CLK),
      .rst_n  (RST_N),
      .re     (RE[i] && idle_c),
      .raddr  (raddr_c),
      .rdata  (rword_c),
      .we     (we_c),
      .waddr  (WADDR),
      .wdata  (D),
      .q      (Q[RD +: DATA_W]),
      .rvalid (RVALID[i])
    );
  end

endmodule

// File: tb/tb_param_memory.sv
// Directed and randomized checks of param_memory against a word-array reference model.
module tb_param_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       we, clr, busy;
  logic [1:0] waddr;
  logic [2:0] d;
  logic [1:0] re, rvalid;
  logic [3:0] raddr;
  logic [5:0] q;

  logic        s_we, s_clr, s_busy;
  logic [3:0]  s_waddr;
  logic [7:0]  s_d;
  logic [2:0]  s_re, s_rvalid;
  logic [11:0] s_raddr;
  logic [23:0] s_q;

  param_memory dut (
    .CLK(clk), .RST_N(rst_n), .WE(we), .WADDR(waddr), .D(d), .RE(re),
    .RADDR(raddr), .Q(q), .RVALID(rvalid), .CLR(clr), .BUSY(busy)
  );

  param_memory #(.DATA_W(8), .ADDR_W(4), .NRD(3)) dut_s (
    .CLK(clk), .RST_N(rst_n), .WE(s_we), .WADDR(s_waddr), .D(s_d), .RE(s_re),
    .RADDR(s_raddr), .Q(s_q), .RVALID(s_rvalid), .CLR(s_clr), .BUSY(s_busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: word contents, expected port outputs, remaining sweep cycles.
  int mm [4];
  int eq [2];
  int erv [2];
  int sweep_left;
  int busy_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) mm[k] = 0;
    eq = '{0, 0};
    erv = '{0, 0};
    sweep_left = 0;
  endtask

  task automatic step(input logic w, input int wa, input int dd, input logic [1:0] r,
                      input int a0, input int a1, input logic c, input string tag);
    int ra [2];
    we = w; waddr = 2'(wa); d = 3'(dd); re = r; raddr = {2'(a1), 2'(a0)}; clr = c;
    ra[0] = a0; ra[1] = a1;
    if (sweep_left > 0) begin
      mm[4 - sweep_left] = 0;
      sweep_left--;
      erv = '{0, 0};
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (r[p]) begin
          eq[p]  = (w && !c && ra[p] == wa) ? dd : mm[ra[p]];
          erv[p] = 1;
        end else begin
          erv[p] = 0;
        end
      end
      if (c) sweep_left = 4;
      else if (w) mm[wa] = dd;
    end
    @(posedge clk); #1;
    if (busy === 1'b1) busy_seen++;
    check({tag, ".q0"},  32'(q[2:0]),    32'(eq[0]));
    check({tag, ".q1"},  32'(q[5:3]),    32'(eq[1]));
    check({tag, ".rv0"}, 32'(rvalid[0]), 32'(erv[0]));
    check({tag, ".rv1"}, 32'(rvalid[1]), 32'(erv[1]));
    check({tag, ".busy"}, 32'(busy),     32'(sweep_left > 0));
  endtask

  task automatic idle(input string tag);
    step(1'b0, 0, 0, 2'b00, 0, 0, 1'b0, tag);
  endtask

  task automatic stick();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    we = 0; waddr = 0; d = 0; re = 0; raddr = 0; clr = 0;
    s_we = 0; s_waddr = 0; s_d = 0; s_re = 0; s_raddr = 0; s_clr = 0;
    model_reset();
    busy_seen = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.q", 32'(q), 32'd0);
    check("rst.rvalid", 32'(rvalid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1;

    // Basic write then read, valid for exactly one cycle.
    step(1'b1, 2, 5, 2'b00, 0, 0, 1'b0, "wr2");
    step(1'b0, 0, 0, 2'b01, 2, 0, 1'b0, "rd2");
    idle("hold");

    // Asynchronous reset mid-cycle with Q nonzero.
    #3 rst_n = 1'b0;
    #1;
    check("arst.q", 32'(q), 32'd0);
    check("arst.rvalid", 32'(rvalid), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    #1;

    // Write-first bypass on port 0 while port 1 reads a stored word.
    step(1'b1, 3, 4, 2'b00, 0, 0, 1'b0, "wr3");
    step(1'b1, 1, 6, 2'b11, 1, 3, 1'b0, "byp");
    step(1'b0, 0, 0, 2'b11, 2, 1, 1'b0, "rd1");
    step(1'b1, 0, 3, 2'b11, 0, 0, 1'b0, "bypboth");

    // Fill, then clear with a write and reads attempted during the sweep.
    step(1'b1, 0, 1, 2'b00, 0, 0, 1'b0, "f0");
    step(1'b1, 1, 2, 2'b00, 0, 0, 1'b0, "f1");
    step(1'b1, 2, 3, 2'b00, 0, 0, 1'b0, "f2");
    step(1'b1, 3, 7, 2'b00, 0, 0, 1'b0, "f3");
    busy_seen = 0;
    step(1'b0, 0, 0, 2'b11, 3, 1, 1'b1, "clr");
    for (int k = 0; k < 4; k++) step(1'b1, 0, 5, 2'b11, 0, 2, 1'b0, "swp");
    idle("post");
    check("clr.busy_cycles", 32'(busy_seen), 32'd4);
    step(1'b0, 0, 0, 2'b11, 0, 1, 1'b0, "z01");
    step(1'b0, 0, 0, 2'b11, 2, 3, 1'b0, "z23");

    // Clear and write on the same edge: clear wins.
    step(1'b1, 3, 2, 2'b00, 0, 0, 1'b0, "pre3");
    step(1'b1, 3, 7, 2'b00, 0, 0, 1'b1, "coll");
    for (int k = 0; k < 4; k++) idle("collswp");
    step(1'b0, 0, 0, 2'b11, 3, 3, 1'b0, "coll.rd3");

    // Reset during the second sweep cycle.
    step(1'b1, 2, 6, 2'b00, 0, 0, 1'b0, "m2");
    step(1'b0, 0, 0, 2'b00, 0, 0, 1'b1, "mclr");
    idle("msw1");
    #2 rst_n = 1'b0;
    #1;
    check("msw.busy", 32'(busy), 32'd0);
    check("msw.rvalid", 32'(rvalid), 32'd0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    #1;
    step(1'b1, 1, 3, 2'b00, 0, 0, 1'b0, "msw.wr");
    step(1'b0, 0, 0, 2'b11, 1, 2, 1'b0, "msw.rd");
    step(1'b0, 0, 0, 2'b11, 0, 3, 1'b0, "msw.z");

    // Randomized traffic.
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           1'($urandom_range(0, 15) == 0), "rnd");
    end
    for (int k = 0; k < 4; k++) idle("drain");
    step(1'b0, 0, 0, 2'b11, 0, 1, 1'b0, "fin01");
    step(1'b0, 0, 0, 2'b11, 2, 3, 1'b0, "fin23");

    // Scaled instance: 16 x 8 bits, three read ports.
    for (int k = 0; k < 16; k++) begin
      s_we = 1'b1; s_waddr = 4'(k); s_d = 8'(k * 3);
      stick();
    end
    s_we = 1'b0;
    s_re = 3'b111; s_raddr = {4'd7, 4'd15, 4'd0};
    stick();
    check("s.q0", 32'(s_q[7:0]), 32'd0);
    check("s.q1", 32'(s_q[15:8]), 32'd45);
    check("s.q2", 32'(s_q[23:16]), 32'd21);
    check("s.rvalid", 32'(s_rvalid), 32'd7);
    s_re = 3'b000;
    s_clr = 1'b1;
    stick();
    s_clr = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && s_busy === 1'b1; k++) begin
      n++;
      stick();
    end
    check("s.busy_cycles", 32'(n), 32'd16);
    check("s.busy_end", 32'(s_busy), 32'd0);
    s_re = 3'b111; s_raddr = {4'd7, 4'd15, 4'd3};
    stick();
    check("s.clr_rd", 32'(s_q), 32'd0);
    s_re = 3'b000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
